// File: rtl/matrix_pkg.sv
// matrix_pkg: definitions shared by the matrix loader and writer.
//   state_t  - FSM state encodings for the loader.
//   WORD_W   - width of one matrix element.
//   idx_w()  - width of an index that must count 0..n-1 (never less than 1 bit).
package matrix_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      s_idle = 2'b00,
      s_read = 2'b01,
      s_done = 2'b11
   } state_t;

   function automatic int unsigned idx_w(input int unsigned dim);
      return (dim <= 1) ? 1 : $clog2(dim);
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// matrix_index_counter: walks (i, j) over an n x n matrix in row- or column-major order.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : return to (0, 0)
//   step       : advance to the next element
//   i, j       : current row / column index
//   last       : current element is (n-1, n-1)
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter int unsigned n         = 8,
   parameter bit          COL_MAJOR = 1'b0,
   localparam int unsigned IW       = idx_w(n)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          step,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic          last
);

   // Explicit compare to n-1 so non-power-of-two sizes wrap correctly.
   localparam logic [IW-1:0] MaxIdx = IW'(n - 1);

   logic [IW-1:0] r_i;
   logic [IW-1:0] r_j;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_i <= '0;
         r_j <= '0;
      end else if (step) begin
         if (!COL_MAJOR) begin
            if (r_j != MaxIdx) begin
               r_j <= r_j + 1'b1;
            end else begin
               r_j <= '0;
               r_i <= (r_i != MaxIdx) ? r_i + 1'b1 : '0;
            end
         end else begin
            if (r_i != MaxIdx) begin
               r_i <= r_i + 1'b1;
            end else begin
               r_i <= '0;
               r_j <= (r_j != MaxIdx) ? r_j + 1'b1 : '0;
            end
         end
      end
   end

   assign i    = r_i;
   assign j    = r_j;
   assign last = (r_i == MaxIdx) && (r_j == MaxIdx);

endmodule

// File: rtl/matrix_reader.sv
// matrix_reader: loads an n x n matrix from a strobe/ack word stream into the operand buffer.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin a transfer (only honoured when idle)
//   in_stb, in_data     : source word valid / word
//   in_ack              : one-cycle pulse, word taken
//   wr_en, wr_i, wr_j,
//   wr_data             : one-cycle buffer write strobe with position and word
//   busy                : transfer in progress
//   done                : full matrix loaded; held until the next start
module matrix_reader
   import matrix_pkg::*;
#(
   parameter int unsigned n         = 8,
   parameter bit          COL_MAJOR = 1'b0,
   localparam int unsigned IW       = idx_w(n)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_stb,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ack,
   output logic              wr_en,
   output logic [IW-1:0]     wr_i,
   output logic [IW-1:0]     wr_j,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   state_t            r_state;
   logic              r_in_ack;
   logic              r_wr_en;
   logic [IW-1:0]     r_wr_i;
   logic [IW-1:0]     r_wr_j;
   logic [WORD_W-1:0] r_wr_data;
   logic              r_busy;
   logic              r_done;

   logic          w_start_ok;
   logic          w_accept;
   logic [IW-1:0] w_i;
   logic [IW-1:0] w_j;
   logic          w_last;

   assign w_start_ok = (r_state == s_idle) && start;
   // The in_ack term blocks a second capture while the source still holds in_stb.
   assign w_accept   = (r_state == s_read) && in_stb && !r_in_ack;

   matrix_index_counter #(
      .n         (n),
      .COL_MAJOR (COL_MAJOR)
   ) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_start_ok),
      .step  (w_accept),
      .i     (w_i),
      .j     (w_j),
      .last  (w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= s_idle;
         r_in_ack  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_i    <= '0;
         r_wr_j    <= '0;
         r_wr_data <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_in_ack <= 1'b0;
         r_wr_en  <= 1'b0;
         case (r_state)
            s_idle: begin
               if (start) begin
                  r_state <= s_read;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            s_read: begin
               if (w_accept) begin
                  r_in_ack  <= 1'b1;
                  r_wr_en   <= 1'b1;
                  r_wr_i    <= w_i;
                  r_wr_j    <= w_j;
                  r_wr_data <= in_data;
                  if (w_last) begin
                     r_state <= s_done;
                     r_busy  <= 1'b0;
                  end
               end
            end
            s_done: begin
               r_done  <= 1'b1;
               r_state <= s_idle;
            end
            default: begin
               r_state <= s_idle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ack  = r_in_ack;
   assign wr_en   = r_wr_en;
   assign wr_i    = r_wr_i;
   assign wr_j    = r_wr_j;
   assign wr_data = r_wr_data;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader: directed bench for matrix_reader. Four instances cover n=8 row-major,
// n=3 column-major, n=5 and n=1; a select variable routes stimulus and observed outputs.
module tb_matrix_reader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_stb = 1'b0;
   logic [31:0] in_data = '0;
   int          sel = 0;

   always #5 clk = ~clk;

   logic [3:0]  s_start, s_stb, s_ack, s_wen, s_busy, s_done;
   logic [31:0] s_wd [4];
   logic [2:0]  wi0, wj0, wi2, wj2;
   logic [1:0]  wi1, wj1;
   logic [0:0]  wi3, wj3;

   assign s_start[0] = start && (sel == 0);
   assign s_start[1] = start && (sel == 1);
   assign s_start[2] = start && (sel == 2);
   assign s_start[3] = start && (sel == 3);
   assign s_stb[0]   = in_stb && (sel == 0);
   assign s_stb[1]   = in_stb && (sel == 1);
   assign s_stb[2]   = in_stb && (sel == 2);
   assign s_stb[3]   = in_stb && (sel == 3);

   matrix_reader #(.n(8), .COL_MAJOR(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(s_start[0]), .in_stb(s_stb[0]), .in_data(in_data),
      .in_ack(s_ack[0]), .wr_en(s_wen[0]), .wr_i(wi0), .wr_j(wj0), .wr_data(s_wd[0]),
      .busy(s_busy[0]), .done(s_done[0]));
   matrix_reader #(.n(3), .COL_MAJOR(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(s_start[1]), .in_stb(s_stb[1]), .in_data(in_data),
      .in_ack(s_ack[1]), .wr_en(s_wen[1]), .wr_i(wi1), .wr_j(wj1), .wr_data(s_wd[1]),
      .busy(s_busy[1]), .done(s_done[1]));
   matrix_reader #(.n(5), .COL_MAJOR(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s_start[2]), .in_stb(s_stb[2]), .in_data(in_data),
      .in_ack(s_ack[2]), .wr_en(s_wen[2]), .wr_i(wi2), .wr_j(wj2), .wr_data(s_wd[2]),
      .busy(s_busy[2]), .done(s_done[2]));
   matrix_reader #(.n(1), .COL_MAJOR(1'b0)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(s_start[3]), .in_stb(s_stb[3]), .in_data(in_data),
      .in_ack(s_ack[3]), .wr_en(s_wen[3]), .wr_i(wi3), .wr_j(wj3), .wr_data(s_wd[3]),
      .busy(s_busy[3]), .done(s_done[3]));

   // Outputs of the selected instance, indices zero-extended to 3 bits.
   logic        o_ack, o_wen, o_busy, o_done;
   logic [2:0]  o_wi, o_wj;
   logic [31:0] o_wd;

   always_comb begin
      o_ack  = 1'b0;
      o_wen  = 1'b0;
      o_busy = 1'b0;
      o_done = 1'b0;
      o_wi   = '0;
      o_wj   = '0;
      o_wd   = '0;
      case (sel)
         0: begin o_ack = s_ack[0]; o_wen = s_wen[0]; o_busy = s_busy[0]; o_done = s_done[0];
                  o_wi = wi0; o_wj = wj0; o_wd = s_wd[0]; end
         1: begin o_ack = s_ack[1]; o_wen = s_wen[1]; o_busy = s_busy[1]; o_done = s_done[1];
                  o_wi = {1'b0, wi1}; o_wj = {1'b0, wj1}; o_wd = s_wd[1]; end
         2: begin o_ack = s_ack[2]; o_wen = s_wen[2]; o_busy = s_busy[2]; o_done = s_done[2];
                  o_wi = wi2; o_wj = wj2; o_wd = s_wd[2]; end
         default: begin o_ack = s_ack[3]; o_wen = s_wen[3]; o_busy = s_busy[3];
                  o_done = s_done[3]; o_wi = {2'b0, wi3}; o_wj = {2'b0, wj3}; o_wd = s_wd[3]; end
      endcase
   end

   int n_cmp = 0;
   int n_err = 0;
   int edge_cnt = 0;
   int wr_cnt = 0;
   int ack_cnt = 0;
   int max_i = 0;

   // Event counters, updated just after each rising edge, well clear of the negedge checks.
   always @(posedge clk) begin
      #2;
      edge_cnt++;
      if (o_wen === 1'b1) begin
         wr_cnt++;
         if (int'(o_wi) > max_i) max_i = int'(o_wi);
      end
      if (o_ack === 1'b1) ack_cnt++;
   end

   // Start a transfer on instance s and feed nwords words; completes with done checks when
   // nwords covers the whole matrix. Returns the cycle (start cycle = 1) at which done rose.
   task automatic run_transfer(input int s, input int nn, input int col, input int nwords,
                               input int max_gap, input int pulse_k, input int base,
                               output int done_cyc);
      int  wr0, e0, e_last, ii, jj, g;
      bit  got;
      sel      = s;
      wr0      = wr_cnt;
      max_i    = 0;
      done_cyc = -1;
      start    = 1'b1;
      e0       = edge_cnt;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
         n_err++;
         $display("FAIL start_sel%0d busy=%b done=%b required busy=1 done=0", s, o_busy, o_done);
      end
      for (int k = 0; k < nwords; k++) begin
         ii      = (col != 0) ? k % nn : k / nn;
         jj      = (col != 0) ? k / nn : k % nn;
         in_stb  = 1'b1;
         in_data = 32'(base + k);
         if (k == pulse_k) start = 1'b1;
         got = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = (o_ack === 1'b1);
         end
         start = 1'b0;
         n_cmp++;
         if (!got || o_wen !== 1'b1 || o_wi !== 3'(ii) || o_wj !== 3'(jj)
             || o_wd !== 32'(base + k)) begin
            n_err++;
            $display("FAIL write_sel%0d_k%0d ack=%b wen=%b i=%0d j=%0d data=%0h required ack=1 wen=1 i=%0d j=%0d data=%0h",
                     s, k, got, o_wen, o_wi, o_wj, o_wd, ii, jj, 32'(base + k));
         end
         if (k == nwords - 1) begin
            in_stb = 1'b0;
         end else if (max_gap > 0) begin
            g = $urandom_range(max_gap, 0);
            if (g > 0) begin
               in_stb = 1'b0;
               repeat (g) @(negedge clk);
            end
         end
      end
      in_stb = 1'b0;
      if (nwords == nn * nn) begin
         e_last = edge_cnt;
         n_cmp++;
         if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL after_last_sel%0d busy=%b done=%b required busy=0 done=0",
                     s, o_busy, o_done);
         end
         for (int c = 0; c < 5 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) done_cyc = edge_cnt - e0 + 1;
         end
         n_cmp++;
         if (done_cyc < 0 || edge_cnt != e_last + 1) begin
            n_err++;
            $display("FAIL done_rise_sel%0d seen_after=%0d edges required 1", s, edge_cnt - e_last);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (wr_cnt - wr0 != nwords || max_i >= nn) begin
         n_err++;
         $display("FAIL write_count_sel%0d writes=%0d max_i=%0d required writes=%0d max_i<%0d",
                  s, wr_cnt - wr0, max_i, nwords, nn);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      in_stb = 1'b1;
      start  = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_cmp++;
         if ({o_ack, o_wen, o_busy, o_done} !== 4'b0 || o_wi !== 3'd0 || o_wj !== 3'd0
             || o_wd !== 32'd0) begin
            n_err++;
            $display("FAIL reset_sel%0d ack=%b wen=%b busy=%b done=%b i=%0d j=%0d data=%0h required all 0",
                     s, o_ack, o_wen, o_busy, o_done, o_wi, o_wj, o_wd);
         end
      end
      in_stb = 1'b0;
      rst_n  = 1'b1;
      sel    = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc, a0;
      run_transfer(0, 8, 0, 10, 0, -1, 32'hA00, cyc);
      sel    = 0;
      in_stb = 1'b1;
      in_data = 32'hDEAD;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if ({o_ack, o_wen, o_busy, o_done} !== 4'b0 || o_wi !== 3'd0 || o_wj !== 3'd0
          || o_wd !== 32'd0) begin
         n_err++;
         $display("FAIL reset_mid ack=%b wen=%b busy=%b done=%b i=%0d j=%0d data=%0h required all 0",
                  o_ack, o_wen, o_busy, o_done, o_wi, o_wj, o_wd);
      end
      a0 = ack_cnt;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (ack_cnt != a0 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_idle acks=%0d busy=%b required acks=0 busy=0",
                  ack_cnt - a0, o_busy);
      end
      in_stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_load();
      int cyc;
      run_transfer(0, 8, 0, 64, 0, -1, 0, cyc);
      n_cmp++;
      if (cyc != 130) begin
         n_err++;
         $display("FAIL full_load_latency done_cycle=%0d required 130", cyc);
      end
   endtask

   task automatic test_col_major();
      int cyc;
      run_transfer(1, 3, 1, 9, 0, -1, 0, cyc);
   endtask

   task automatic test_stalls();
      int cyc;
      run_transfer(0, 8, 0, 64, 5, -1, 32'h1000, cyc);
   endtask

   task automatic test_ignored();
      int cyc, a0;
      sel    = 0;
      a0     = ack_cnt;
      in_stb = 1'b1;
      in_data = 32'hBEEF;
      repeat (4) @(negedge clk);
      in_stb = 1'b0;
      n_cmp++;
      if (ack_cnt != a0 || o_wen !== 1'b0 || o_done !== 1'b1) begin
         n_err++;
         $display("FAIL idle_ignore acks=%0d wen=%b done=%b required acks=0 wen=0 done=1",
                  ack_cnt - a0, o_wen, o_done);
      end
      run_transfer(0, 8, 0, 64, 1, 20, 32'h2000, cyc);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (o_done !== 1'b1 || o_busy !== 1'b0) begin
         n_err++;
         $display("FAIL done_hold done=%b busy=%b required done=1 busy=0", o_done, o_busy);
      end
   endtask

   task automatic test_sizes();
      int cyc;
      run_transfer(2, 5, 0, 25, 2, -1, 32'h3000, cyc);
      run_transfer(3, 1, 0, 1, 0, -1, 32'h4000, cyc);
      n_cmp++;
      if (cyc != 4) begin
         n_err++;
         $display("FAIL n1_latency done_cycle=%0d required 4", cyc);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_full_load();
      test_col_major();
      test_stalls();
      test_ignored();
      test_sizes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
